// File: rtl/mult_share_rr.sv
// ---------------------------------------------------------------------------
// mult_share_rr
//   Round-robin scheduler that shares one mult_bw Baugh-Wooley multiplier
//   among NUM_REQ requesters. One request is granted per cycle. The product
//   is returned on a registered, back-pressurable response channel that is
//   tagged with the index of the granted requester.
//
//   Optional feature macro: MULT_SHARE_RR_INREG_EN
//     defined   : a registered input stage (operands, mode, id, valid) sits
//                 between the arbiter and mult_bw, giving 2-cycle latency.
//     undefined : single-stage datapath with 1-cycle latency.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     req_valid_i     per-requester request valid
//     req_ready_o     per-requester accept (one-hot or zero)
//     req_tc_mode_i   per-requester mode: 1 = signed, 0 = unsigned
//     req_a_i/req_b_i packed operands, requester k at [k*DW +: DW]
//     rsp_valid_o     response valid
//     rsp_ready_i     response consumer ready
//     rsp_id_o        index of the requester that owns the response
//     rsp_c_o         full-width product
//
//   This file also holds the small math_pkg and mult_bw pieces it depends on.
// ---------------------------------------------------------------------------

package math_pkg;
    // Encoding selector for mult_bw
    localparam int MBE_IV = 0;  // inverted-MSB correction form
    localparam int MBE_SX = 1;  // sign-extension form
endpackage

// mult_bw: full-width A_DW x B_DW multiplier, signed or unsigned per tc_mode.
module mult_bw #(
    parameter int A_DW = 8,
    parameter int B_DW = 8,
    parameter int MBE  = math_pkg::MBE_IV
) (
    input  logic [A_DW-1:0]      a,
    input  logic [B_DW-1:0]      b,
    input  logic                 tc_mode,
    output logic [A_DW+B_DW-1:0] c
);
    localparam int P_DW = A_DW + B_DW;

    generate
        if (MBE == math_pkg::MBE_IV) begin : g_iv
            logic [P_DW-1:0] raw_s;
            logic [P_DW-1:0] corr_a_s;
            logic [P_DW-1:0] corr_b_s;

            // Unsigned product minus the weight contributed by negative MSBs;
            // the MSB*MSB term lands at 2^P_DW and vanishes modulo the width.
            always_comb begin
                raw_s    = {{B_DW{1'b0}}, a} * {{A_DW{1'b0}}, b};
                corr_a_s = (tc_mode && a[A_DW-1]) ? ({{A_DW{1'b0}}, b} << A_DW) : {P_DW{1'b0}};
                corr_b_s = (tc_mode && b[B_DW-1]) ? ({{B_DW{1'b0}}, a} << B_DW) : {P_DW{1'b0}};
                c        = raw_s - corr_a_s - corr_b_s;
            end
        end else begin : g_sx
            logic [P_DW-1:0] a_ext_s;
            logic [P_DW-1:0] b_ext_s;

            // Sign- or zero-extend both operands to product width and multiply.
            always_comb begin
                a_ext_s = {{B_DW{tc_mode & a[A_DW-1]}}, a};
                b_ext_s = {{A_DW{tc_mode & b[B_DW-1]}}, b};
                c       = a_ext_s * b_ext_s;
            end
        end
    endgenerate
endmodule

module mult_share_rr #(
    parameter  int NUM_REQ = 4,
    parameter  int A_DW    = 8,
    parameter  int B_DW    = 8,
    parameter  int MBE     = math_pkg::MBE_IV,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_tc_mode_i,
    input  logic [NUM_REQ*A_DW-1:0]   req_a_i,
    input  logic [NUM_REQ*B_DW-1:0]   req_b_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [A_DW+B_DW-1:0]      rsp_c_o
);
    localparam int P_DW = A_DW + B_DW;

    logic [ID_W-1:0]   rr_ptr_r;
    logic              found_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [A_DW-1:0]   sel_a_s;
    logic [B_DW-1:0]   sel_b_s;
    logic              sel_tc_s;
    logic              accept_s;
    logic              hs_s;

    logic [A_DW-1:0]   mult_a_s;
    logic [B_DW-1:0]   mult_b_s;
    logic              mult_tc_s;
    logic [P_DW-1:0]   product_s;

    logic              out_valid_r;
    logic [ID_W-1:0]   out_id_r;
    logic [P_DW-1:0]   out_c_r;

    // Round-robin search: scan from rr_ptr downward in priority; iterating the
    // offsets from far to near lets the nearest valid requester win.
    always_comb begin : p_grant
        int idx;
        idx        = 0;
        found_s    = |req_valid_i;
        grant_id_s = {ID_W{1'b0}};
        sel_a_s    = {A_DW{1'b0}};
        sel_b_s    = {B_DW{1'b0}};
        sel_tc_s   = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx        = int'(rr_ptr_r) + i;
            idx        = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
            grant_id_s = req_valid_i[idx] ? ID_W'(idx)                 : grant_id_s;
            sel_a_s    = req_valid_i[idx] ? req_a_i[idx*A_DW +: A_DW]  : sel_a_s;
            sel_b_s    = req_valid_i[idx] ? req_b_i[idx*B_DW +: B_DW]  : sel_b_s;
            sel_tc_s   = req_valid_i[idx] ? req_tc_mode_i[idx]         : sel_tc_s;
        end
    end

    assign hs_s = found_s && accept_s;

    // One-hot ready toward the granted requester, only when it can be taken.
    always_comb begin
        req_ready_o = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = hs_s && (grant_id_s == ID_W'(k));
        end
    end

    // Pointer moves just past the requester that completed a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (hs_s) begin
            rr_ptr_r <= (grant_id_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_id_s + ID_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

`ifdef MULT_SHARE_RR_INREG_EN
    logic              in_valid_r;
    logic [ID_W-1:0]   in_id_r;
    logic [A_DW-1:0]   in_a_r;
    logic [B_DW-1:0]   in_b_r;
    logic              in_tc_r;
    logic              out_adv_s;

    // Reset holds accept low so nothing is granted while rst_n is asserted.
    assign out_adv_s = !out_valid_r || rsp_ready_i;
    assign accept_s  = rst_n && (!in_valid_r || out_adv_s);
    assign mult_a_s  = in_a_r;
    assign mult_b_s  = in_b_r;
    assign mult_tc_s = in_tc_r;

    // Input stage: captures the granted request whenever it can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_r <= 1'b0;
            in_id_r    <= {ID_W{1'b0}};
            in_a_r     <= {A_DW{1'b0}};
            in_b_r     <= {B_DW{1'b0}};
            in_tc_r    <= 1'b0;
        end else if (accept_s) begin
            in_valid_r <= hs_s;
            if (hs_s) begin
                in_id_r <= grant_id_s;
                in_a_r  <= sel_a_s;
                in_b_r  <= sel_b_s;
                in_tc_r <= sel_tc_s;
            end else begin
                in_id_r <= in_id_r;
                in_a_r  <= in_a_r;
                in_b_r  <= in_b_r;
                in_tc_r <= in_tc_r;
            end
        end else begin
            in_valid_r <= in_valid_r;
        end
    end

    // Output stage: takes the product of the input stage when empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_id_r    <= {ID_W{1'b0}};
            out_c_r     <= {P_DW{1'b0}};
        end else if (out_adv_s) begin
            out_valid_r <= in_valid_r;
            if (in_valid_r) begin
                out_id_r <= in_id_r;
                out_c_r  <= product_s;
            end else begin
                out_id_r <= out_id_r;
                out_c_r  <= out_c_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
`else
    // Reset holds accept low so nothing is granted while rst_n is asserted.
    assign accept_s  = rst_n && (!out_valid_r || rsp_ready_i);
    assign mult_a_s  = sel_a_s;
    assign mult_b_s  = sel_b_s;
    assign mult_tc_s = sel_tc_s;

    // Output stage: loads on handshake, empties when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_id_r    <= {ID_W{1'b0}};
            out_c_r     <= {P_DW{1'b0}};
        end else if (hs_s) begin
            out_valid_r <= 1'b1;
            out_id_r    <= grant_id_s;
            out_c_r     <= product_s;
        end else if (rsp_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
`endif

    mult_bw #(
        .A_DW (A_DW),
        .B_DW (B_DW),
        .MBE  (MBE)
    ) u_mult_bw (
        .a       (mult_a_s),
        .b       (mult_b_s),
        .tc_mode (mult_tc_s),
        .c       (product_s)
    );

    assign rsp_valid_o = out_valid_r;
    assign rsp_id_o    = out_id_r;
    assign rsp_c_o     = out_c_r;
endmodule

// File: tb/tb_mult_share_rr.sv
// ---------------------------------------------------------------------------
// tb_mult_share_rr
//   Directed bench for mult_share_rr (NUM_REQ=4, 8x8). Expected products and
//   grant orders are hand-computed constants. Latency follows the
//   MULT_SHARE_RR_INREG_EN macro when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_mult_share_rr;
`ifdef MULT_SHARE_RR_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NSEQ = 9;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_tc;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_c;

    int n_checks = 0;
    int n_errors = 0;

    // Grant order: four-way rotation from reset, then only 1 and 3 valid
    // with the pointer at 2.
    int grant_tab [NSEQ] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

    mult_share_rr dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_tc_mode_i (req_tc),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_c_o       (rsp_c)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_op(input int k, input logic tc, input logic [7:0] a, input logic [7:0] b);
        req_tc[k]        = tc;
        req_a[k*8 +: 8]  = a;
        req_b[k*8 +: 8]  = b;
    endtask

    // Single request from requester k; checks ready, then the response LAT cycles on.
    task automatic issue(input string tag, input int k, input logic tc,
                         input logic [7:0] a, input logic [7:0] b, input logic [15:0] expc);
        set_op(k, tc, a, b);
        req_valid = 4'b0001 << k;
        #1;
        check_val({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << k));
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        check_val({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check_val({tag, "_id"},    32'(rsp_id),    32'(k));
        check_val({tag, "_c"},     32'(rsp_c),     32'(expc));
    endtask

    initial begin
        int g;
        clk       = 1'b0;
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        req_tc    = 4'b0000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;

        // Reset state: outputs cleared and no ready despite a valid request
        #3;
        check_val("rst_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_id",    32'(rsp_id),    32'd0);
        check_val("rst_c",     32'(rsp_c),     32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk); #1;

        // Arithmetic in both modes
        issue("s_80x80", 0, 1'b1, 8'h80, 8'h80, 16'h4000);
        issue("u_ffxff", 2, 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        issue("s_ffxff", 2, 1'b1, 8'hFF, 8'hFF, 16'h0001);
        issue("s_7fx80", 1, 1'b1, 8'h7F, 8'h80, 16'hC080);
        issue("u_7fx80", 3, 1'b0, 8'h7F, 8'h80, 16'h3F80);

        // Fairness from reset followed by idle-skip with pointer at 2
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) set_op(k, 1'b0, 8'(k + 1), 8'h10);
        req_valid = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NSEQ + LAT - 1; c++) begin
            if (c < NSEQ) begin
                req_valid = (c < 6) ? 4'b1111 : 4'b1010;
                #1;
                check_val("rr_ready", 32'(req_ready), 32'(4'b0001 << grant_tab[c]));
            end else begin
                req_valid = 4'b0000;
            end
            @(posedge clk); #1;
            if (c - LAT + 1 >= 0) begin
                g = grant_tab[c - LAT + 1];
                check_val("rr_valid", 32'(rsp_valid), 32'd1);
                check_val("rr_id",    32'(rsp_id),    32'(g));
                check_val("rr_c",     32'(rsp_c),     32'((g + 1) * 16));
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;

`ifndef MULT_SHARE_RR_INREG_EN
        // Backpressure: response held, no ready, pointer frozen at 1
        set_op(0, 1'b0, 8'd3, 8'd5);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        set_op(1, 1'b0, 8'd2, 8'd2);
        set_op(3, 1'b0, 8'd6, 8'd7);
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val("bp_ready", 32'(req_ready), 32'd0);
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_id",    32'(rsp_id),    32'd0);
            check_val("bp_c",     32'(rsp_c),     32'h000F);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check_val("bp_rel_ready", 32'(req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        check_val("bp_rel_id", 32'(rsp_id), 32'd1);
        check_val("bp_rel_c",  32'(rsp_c),  32'h0004);
        req_valid = 4'b1000;
        #1;
        check_val("bp_next_ready", 32'(req_ready), 32'(4'b1000));
        @(posedge clk); #1;
        check_val("bp_next_id", 32'(rsp_id), 32'd3);
        check_val("bp_next_c",  32'(rsp_c),  32'h002A);
        req_valid = 4'b0000;
        @(negedge clk);
`endif

        // Reset while a response is pending
        issue("pre_rst", 2, 1'b0, 8'h10, 8'h10, 16'h0100);
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", 32'(rsp_valid), 32'd0);
        check_val("mrst_c",     32'(rsp_c),     32'd0);
        check_val("mrst_id",    32'(rsp_id),    32'd0);
        set_op(3, 1'b0, 8'd9, 8'd9);
        req_valid = 4'b1100;
        #1;
        check_val("mrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(req_ready), 32'(4'b0100));
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        check_val("post_rst_valid", 32'(rsp_valid), 32'd1);
        check_val("post_rst_id",    32'(rsp_id),    32'd2);
        check_val("post_rst_c",     32'(rsp_c),     32'h0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
